btn_conditioner: RTL and testbench

Multi-channel push-button conditioner. Replaces the single-button fixed 3-tap shift-register pulse detector with a per-channel synchroniser, counter-based debouncer, press/release pulse generator and toggle latch. It sits between the board's raw button pins and any control logic that needs either one-cycle events or a latched on/off state.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 105 ++++++++++
 rtl/btn_conditioner.sv | 39 +++
 tb/tb_btn_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel state encodings,
// default timing constants and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_DISARMING = 2'd3
  } ch_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 50000000;
  localparam int DEF_REPEAT_CYCLES   = 10000000;

  // Bits needed to hold values 0..n (never less than 1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce counter, FSM, press/release pulses,
// toggle latch and (with BTN_HOLD_REPEAT_EN defined) hold auto-repeat.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic toggle
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt, cnt_nxt;
  ch_state_e              state, state_nxt;
  logic                   accept;
  logic                   rep_pulse;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level) && (cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
  end

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    // Any agreeing sample, or an accepted change, restarts the count.
    if (s == level || accept) cnt_nxt = '0;
    else                      cnt_nxt = cnt + 1'b1;
    case (state)
      ST_IDLE:      if (s) state_nxt = accept ? ST_HELD : ST_ARMING;
      ST_ARMING:    if (!s) state_nxt = ST_IDLE;
                    else if (accept) state_nxt = ST_HELD;
      ST_HELD:      if (!s) state_nxt = accept ? ST_IDLE : ST_DISARMING;
      ST_DISARMING: if (s) state_nxt = ST_HELD;
                    else if (accept) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      state         <= ST_IDLE;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      state         <= state_nxt;
      if (accept) level <= s;
      press         <= (accept & s) | rep_pulse;
      release_pulse <= accept & ~s;
      if (accept & s) toggle <= ~toggle;
    end
  end

`ifdef BTN_HOLD_REPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = cnt_width(HMAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          rep_phase;

  // First period is HOLD_CYCLES after the accepted press, then REPEAT_CYCLES each.
  assign rep_pulse = level && !accept &&
                     (hold_cnt == (rep_phase ? REP_LAST : HOLD_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else if (!level || accept) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else if (rep_pulse) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b1;
    end else begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end
`else
  localparam int unused_hold_cfg = HOLD_CYCLES + REPEAT_CYCLES;
  assign rep_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner; one btn_channel per button.
// Optional hold auto-repeat is built when BTN_HOLD_REPEAT_EN is defined.
// The release output is named release_pulse because release is a reserved word.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] toggle
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .button       (button[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .toggle       (toggle[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised + directed bench for btn_conditioner against a window-based
// behavioural model (a level change is accepted once the last DB synchronised
// samples all disagree with it).
module tb_btn_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int HC = 20;
  localparam int RC = 5;
`ifdef BTN_HOLD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] button;
  logic [CH-1:0] level, press, release_pulse, toggle;

  btn_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .level(level),
    .press(press), .release_pulse(release_pulse), .toggle(toggle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  logic [SS-1:0] bh [CH];
  logic [DB-1:0] wv [CH];
  logic [CH-1:0] lvl_m, prs_m, rel_m, tog_m;
  int            t0 [CH];
  int            now;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      bh[c] = '0; wv[c] = '0; t0[c] = 0;
    end
    lvl_m = '0; prs_m = '0; rel_m = '0; tog_m = '0; now = 0;
  endtask

  task automatic model_step(input logic [CH-1:0] b);
    logic so;
    int   k;
    now++;
    for (int c = 0; c < CH; c++) begin
      so       = bh[c][SS-1];
      bh[c]    = {bh[c][SS-2:0], b[c]};
      wv[c]    = {wv[c][DB-2:0], so};
      prs_m[c] = 1'b0;
      rel_m[c] = 1'b0;
      if (wv[c] == {DB{~lvl_m[c]}}) begin
        if (so) begin
          lvl_m[c] = 1'b1; tog_m[c] = ~tog_m[c]; prs_m[c] = 1'b1; t0[c] = now;
        end else begin
          lvl_m[c] = 1'b0; rel_m[c] = 1'b1;
        end
      end else if (REP_EN && lvl_m[c]) begin
        k = now - t0[c];
        if (k == HC || (k > HC && (k - HC) % RC == 0)) prs_m[c] = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic [CH-1:0] b);
    button = b;
    @(posedge clk);
    model_step(b);
    #1;
    chk("level", 32'(level), 32'(lvl_m));
    chk("press", 32'(press), 32'(prs_m));
    chk("release", 32'(release_pulse), 32'(rel_m));
    chk("toggle", 32'(toggle), 32'(tog_m));
    if ((press & release_pulse) != '0) chk("press_and_release", 32'(press & release_pulse), 0);
  endtask

  int n_press;
  logic [CH-1:0] rb;

  initial begin
    rst = 1'b0; button = '0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_press", 32'(press), 0);
    chk("rst_release", 32'(release_pulse), 0);
    chk("rst_toggle", 32'(toggle), 0);
    @(negedge clk) rst = 1'b1;

    // clean press on channel 0
    for (int i = 1; i <= 8; i++) begin
      tick(4'b0001);
      if (i == 5) chk("lat5_level", 32'(level[0]), 0);
      if (i == 6) begin
        chk("lat6_level", 32'(level[0]), 1);
        chk("lat6_press", 32'(press), 32'h1);
      end
      if (i == 7) chk("press_one_cycle", 32'(press[0]), 0);
    end
    chk("clean_toggle", 32'(toggle), 32'h1);

    // bounce on channel 1 (3 high, 1 low)
    for (int i = 0; i < 32; i++) tick({2'b00, (i % 4) != 3, 1'b1});
    chk("bounce_level1", 32'(level[1]), 0);
    chk("bounce_toggle1", 32'(toggle[1]), 0);

    // release and second press on channel 0
    for (int i = 0; i < 12; i++) tick(4'b0000);
    chk("rel_toggle0", 32'(toggle[0]), 1);
    for (int i = 0; i < 12; i++) tick(4'b0001);
    chk("second_toggle0", 32'(toggle[0]), 0);

    // all channels together
    for (int i = 0; i < 12; i++) tick(4'b0000);
    n_press = 0;
    for (int i = 0; i < 12; i++) begin
      tick(4'b1111);
      if (press == 4'hF) n_press++;
    end
    chk("simul_press", 32'(n_press), 1);
    chk("simul_toggle", 32'(toggle), 32'hF);

    // hold channel 2: accept at tick 6, repeats at +20 then every +5
    for (int i = 0; i < 12; i++) tick(4'b0000);
    n_press = 0;
    for (int i = 0; i < 51; i++) begin
      tick(4'b0100);
      if (press[2]) n_press++;
    end
    chk("hold_press_count", 32'(n_press), REP_EN ? 7 : 1);
    chk("hold_toggle2", 32'(toggle[2]), 0);
    n_press = 0;
    for (int i = 0; i < 30; i++) begin
      tick(4'b0000);
      if (press[2]) n_press++;
    end
    chk("after_release_press", 32'(n_press), 0);

    // random traffic mixing glitches and stable runs
    rb = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
      tick(rb);
    end

    // asynchronous reset in the middle of a count
    for (int i = 0; i < 12; i++) tick(4'b0000);
    for (int i = 0; i < 12; i++) tick(4'b1111);
    for (int i = 0; i < 3; i++) tick(4'b0000);
    rst = 1'b0;
    #1;
    chk("async_level", 32'(level), 0);
    chk("async_toggle", 32'(toggle), 0);
    chk("async_press", 32'(press | release_pulse), 0);
    chk("async_cnt", 32'(dut.g_ch[0].u_ch.cnt), 0);
    model_reset();
    button = 4'b1111;
    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(4'b1111);
      if (i == 6) chk("held_at_reset_press", 32'(press), 32'hF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
